dma_ring_tracker: RTL and testbench

DMA_RING_TRACKER -- requirements
Module: dma_ring_tracker

---
 rtl/dma_ring_tracker.sv | 127 ++++++++++++
 tb/tb_dma_ring_tracker.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_ring_tracker.sv
// Tracks completed S2MM datamover blocks in a host ring buffer: write pointer, fill level,
// interrupt coalescing, and sticky overrun/status-error reporting with a run/halt/fault FSM.
module dma_ring_tracker (
    input  logic        axi_aclk,
    input  logic        axi_aresetn,
    input  logic        enable,
    input  logic        err_clr,
    input  logic        s_axis_sts_tvalid,
    output logic        s_axis_sts_tready,
    input  logic [7:0]  s_axis_sts_tdata,
    input  logic [15:0] ring_blocks_m1,
    input  logic [15:0] host_rd_ptr,
    input  logic [7:0]  irq_threshold,
    input  logic        irq_ack,
    output logic [15:0] wr_ptr,
    output logic [16:0] fill_level,
    output logic        irq,
    output logic        overrun,
    output logic        sts_err,
    output logic        halt_req,
    output logic [2:0]  err_code,
    output logic [31:0] blocks_total
);

    typedef enum logic [1:0] {StIdle, StRun, StHalt, StFault} state_e;

    state_e      state_q, state_d;
    logic [3:0]  tag_q;
    logic [7:0]  irq_count_q;
    logic [15:0] wr_ptr_d;
    logic [16:0] fill_now;
    logic [2:0]  err_sel;
    logic        beat_acc, beat_good, good_acc, bad_acc, run_start, ring_full, irq_hit;

    // Blocks held by the host; the else-branch covers a writer that has wrapped past the reader.
    function automatic logic [16:0] fill_calc(input logic [15:0] wr, input logic [15:0] rd,
                                              input logic [15:0] m1);
        if (wr >= rd) fill_calc = {1'b0, wr} - {1'b0, rd};
        else          fill_calc = {1'b0, wr} + {1'b0, m1} + 17'd1 - {1'b0, rd};
    endfunction

    assign beat_acc  = s_axis_sts_tvalid & s_axis_sts_tready;
    assign beat_good = s_axis_sts_tdata[7] & ~|s_axis_sts_tdata[6:4]
                     & (s_axis_sts_tdata[3:0] == tag_q) & (host_rd_ptr <= ring_blocks_m1);
    assign good_acc  = beat_acc & beat_good;
    assign bad_acc   = beat_acc & ~beat_good;
    assign run_start = (state_q == StIdle) & enable;
    assign fill_now  = fill_calc(wr_ptr, host_rd_ptr, ring_blocks_m1);
    assign ring_full = (fill_now == {1'b0, ring_blocks_m1});
    assign irq_hit   = good_acc & (irq_threshold != 8'd0)
                     & (({1'b0, irq_count_q} + 9'd1) == {1'b0, irq_threshold});

    always_comb begin
        err_sel = 3'b110;
        if (s_axis_sts_tdata[4])                       err_sel = 3'b001;
        else if (s_axis_sts_tdata[5])                  err_sel = 3'b010;
        else if (s_axis_sts_tdata[6])                  err_sel = 3'b011;
        else if (s_axis_sts_tdata[3:0] != tag_q)       err_sel = 3'b100;
        else if (host_rd_ptr > ring_blocks_m1)         err_sel = 3'b101;
    end

    always_comb begin
        wr_ptr_d = wr_ptr;
        if (run_start)     wr_ptr_d = 16'd0;
        else if (good_acc) wr_ptr_d = (wr_ptr == ring_blocks_m1) ? 16'd0 : wr_ptr + 16'd1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (enable) state_d = StRun;
            default: begin
                if (good_acc)     state_d = ring_full ? StHalt : StRun;
                else if (bad_acc) state_d = StFault;
                if (!enable)      state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q           <= StIdle;
            tag_q             <= 4'd0;
            irq_count_q       <= 8'd0;
            s_axis_sts_tready <= 1'b0;
            wr_ptr            <= 16'd0;
            fill_level        <= 17'd0;
            irq               <= 1'b0;
            overrun           <= 1'b0;
            sts_err           <= 1'b0;
            halt_req          <= 1'b0;
            err_code          <= 3'd0;
            blocks_total      <= 32'd0;
        end else begin
            state_q           <= state_d;
            s_axis_sts_tready <= (state_d == StRun);
            halt_req          <= (state_d == StHalt) || (state_d == StFault);
            wr_ptr            <= wr_ptr_d;
            fill_level        <= fill_calc(wr_ptr_d, host_rd_ptr, ring_blocks_m1);

            if (run_start) begin
                tag_q       <= 4'd0;
                irq_count_q <= 8'd0;
            end else if (good_acc) begin
                tag_q <= tag_q + 4'd1;
                if (irq_threshold != 8'd0) irq_count_q <= irq_hit ? 8'd0 : irq_count_q + 8'd1;
            end

            if (good_acc) blocks_total <= blocks_total + 32'd1;

            irq <= irq_hit | (irq & ~irq_ack);

            // Clear first so an error in the same cycle overrides it and counts as the first.
            if (err_clr) begin
                overrun  <= 1'b0;
                sts_err  <= 1'b0;
                err_code <= 3'd0;
            end
            if (good_acc && ring_full) overrun <= 1'b1;
            if (bad_acc) begin
                sts_err <= 1'b1;
                if (!sts_err || err_clr) err_code <= err_sel;
            end
        end
    end

endmodule

// File: tb/tb_dma_ring_tracker.sv
// Self-checking bench for dma_ring_tracker: directed scenarios plus randomized traffic
// checked against a behavioural ring model.
module tb_dma_ring_tracker;

    localparam int MODE_IDLE  = 0;
    localparam int MODE_RUN   = 1;
    localparam int MODE_HALT  = 2;
    localparam int MODE_FAULT = 3;

    logic        axi_aclk = 1'b0;
    logic        axi_aresetn = 1'b0;
    logic        enable = 1'b0;
    logic        err_clr = 1'b0;
    logic        s_axis_sts_tvalid = 1'b0;
    logic        s_axis_sts_tready;
    logic [7:0]  s_axis_sts_tdata = 8'h00;
    logic [15:0] ring_blocks_m1 = 16'd0;
    logic [15:0] host_rd_ptr = 16'd0;
    logic [7:0]  irq_threshold = 8'd0;
    logic        irq_ack = 1'b0;
    logic [15:0] wr_ptr;
    logic [16:0] fill_level;
    logic        irq, overrun, sts_err, halt_req;
    logic [2:0]  err_code;
    logic [31:0] blocks_total;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int          m_mode;
    int unsigned m_wr, m_tag, m_cnt, m_fill, m_code, m_total;
    bit          m_irq, m_ovr, m_err;

    dma_ring_tracker dut (
        .axi_aclk          (axi_aclk),
        .axi_aresetn       (axi_aresetn),
        .enable            (enable),
        .err_clr           (err_clr),
        .s_axis_sts_tvalid (s_axis_sts_tvalid),
        .s_axis_sts_tready (s_axis_sts_tready),
        .s_axis_sts_tdata  (s_axis_sts_tdata),
        .ring_blocks_m1    (ring_blocks_m1),
        .host_rd_ptr       (host_rd_ptr),
        .irq_threshold     (irq_threshold),
        .irq_ack           (irq_ack),
        .wr_ptr            (wr_ptr),
        .fill_level        (fill_level),
        .irq               (irq),
        .overrun           (overrun),
        .sts_err           (sts_err),
        .halt_req          (halt_req),
        .err_code          (err_code),
        .blocks_total      (blocks_total)
    );

    always #5 axi_aclk = ~axi_aclk;

    wire [72:0] dut_vec = {s_axis_sts_tready, wr_ptr, fill_level, irq, overrun, sts_err,
                           halt_req, err_code, blocks_total};

    function automatic int unsigned fill_of(int unsigned wr, int unsigned rd, int unsigned m1);
        if (wr >= rd) return wr - rd;
        return (wr + m1 + 1 - rd) & 32'h1ffff;
    endfunction

    function automatic void model_reset();
        m_mode = MODE_IDLE;
        m_wr = 0; m_tag = 0; m_cnt = 0; m_fill = 0; m_code = 0; m_total = 0;
        m_irq = 0; m_ovr = 0; m_err = 0;
    endfunction

    function automatic logic [72:0] exp_vec();
        return {(m_mode == MODE_RUN), 16'(m_wr), 17'(m_fill), m_irq, m_ovr, m_err,
                (m_mode == MODE_HALT || m_mode == MODE_FAULT), 3'(m_code), 32'(m_total)};
    endfunction

    // One clock of the ring as described behaviourally: inputs are those present at the edge.
    function automatic void model_step();
        int unsigned rd, m1, fill_before, code;
        bit accepted, good, irq_set;
        int nm;
        if (!axi_aresetn) begin
            model_reset();
            return;
        end
        rd = host_rd_ptr;
        m1 = ring_blocks_m1;
        irq_set = 0;
        accepted = s_axis_sts_tvalid && (m_mode == MODE_RUN);
        good = s_axis_sts_tdata[7] && (s_axis_sts_tdata[6:4] == 3'b000)
               && (s_axis_sts_tdata[3:0] == 4'(m_tag)) && (rd <= m1);
        if (s_axis_sts_tdata[4])                         code = 1;
        else if (s_axis_sts_tdata[5])                    code = 2;
        else if (s_axis_sts_tdata[6])                    code = 3;
        else if (s_axis_sts_tdata[3:0] != 4'(m_tag))     code = 4;
        else if (rd > m1)                                code = 5;
        else                                             code = 6;
        fill_before = fill_of(m_wr, rd, m1);
        if (err_clr) begin
            m_ovr = 0; m_err = 0; m_code = 0;
        end
        if (m_mode == MODE_IDLE) begin
            if (enable) begin
                m_mode = MODE_RUN; m_wr = 0; m_tag = 0; m_cnt = 0;
            end
        end else begin
            nm = m_mode;
            if (accepted && good) begin
                m_wr = (m_wr == m1) ? 0 : ((m_wr + 1) & 32'hffff);
                m_tag = (m_tag + 1) % 16;
                m_total = m_total + 1;
                if (irq_threshold != 0) begin
                    if (m_cnt + 1 == irq_threshold) begin
                        irq_set = 1; m_cnt = 0;
                    end else m_cnt = (m_cnt + 1) & 32'hff;
                end
                if (fill_before == m1) begin
                    m_ovr = 1; nm = MODE_HALT;
                end
            end else if (accepted) begin
                if (!m_err) m_code = code;
                m_err = 1;
                nm = MODE_FAULT;
            end
            if (!enable) nm = MODE_IDLE;
            m_mode = nm;
        end
        m_irq = irq_set || (m_irq && !irq_ack);
        m_fill = fill_of(m_wr, rd, m1);
    endfunction

    task automatic tick();
        @(posedge axi_aclk);
        model_step();
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d);
        s_axis_sts_tvalid = 1'b1;
        s_axis_sts_tdata  = d;
        tick();
        s_axis_sts_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        enable = 1'b0; err_clr = 1'b0; irq_ack = 1'b0; s_axis_sts_tvalid = 1'b0;
        axi_aresetn = 1'b0;
        model_reset();
        tick();
        axi_aresetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (dut_vec !== 73'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", dut_vec);
        end
        enable = 1'b1;
        tick();
        n_vec++;
        if (s_axis_sts_tready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_enter_run: tready got %b want 1", s_axis_sts_tready);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        ring_blocks_m1 = 16'd3; host_rd_ptr = 16'd0; irq_threshold = 8'd0;
        enable = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) send_beat(8'h80 | 8'(i));
        n_vec++;
        if ({wr_ptr, fill_level, overrun} !== {16'd3, 17'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL ring_three_beats: wr=%0d fill=%0d ovr=%b want 3 3 0",
                     wr_ptr, fill_level, overrun);
        end
        send_beat(8'h83);
        n_vec++;
        if ({overrun, halt_req, wr_ptr} !== {1'b1, 1'b1, 16'd0}) begin
            n_bad++;
            $display("FAIL ring_overrun: ovr=%b halt=%b wr=%0d want 1 1 0",
                     overrun, halt_req, wr_ptr);
        end
    endtask

    task automatic test_irq();
        do_reset();
        ring_blocks_m1 = 16'd15; host_rd_ptr = 16'd0; irq_threshold = 8'd4;
        enable = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            irq_ack = (i == 4 || i == 7);
            send_beat(8'h80 | 8'(i));
            irq_ack = 1'b0;
            if (i == 2 || i == 3 || i == 4 || i == 7) begin
                n_vec++;
                if (irq !== ((i == 3 || i == 7) ? 1'b1 : 1'b0)) begin
                    n_bad++;
                    $display("FAIL irq_after_beat%0d: got %b want %b", i + 1, irq,
                             (i == 3 || i == 7));
                end
            end
        end
    endtask

    task automatic test_fault();
        do_reset();
        ring_blocks_m1 = 16'd15; host_rd_ptr = 16'd0; irq_threshold = 8'd0;
        enable = 1'b1;
        tick();
        send_beat(8'h90);
        n_vec++;
        if ({halt_req, sts_err, err_code, wr_ptr, s_axis_sts_tready}
            !== {1'b1, 1'b1, 3'b001, 16'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL fault_interr: halt=%b err=%b code=%0d wr=%0d rdy=%b want 1 1 1 0 0",
                     halt_req, sts_err, err_code, wr_ptr, s_axis_sts_tready);
        end
        send_beat(8'hA0);
        n_vec++;
        if ({err_code, blocks_total} !== {3'b001, 32'd0}) begin
            n_bad++;
            $display("FAIL fault_ignores_beat: code=%0d total=%0d want 1 0", err_code,
                     blocks_total);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_vec++;
        if ({err_code, sts_err} !== 4'd0) begin
            n_bad++;
            $display("FAIL fault_err_clr: code=%0d err=%b want 0 0", err_code, sts_err);
        end
    endtask

    task automatic test_tag_mismatch();
        do_reset();
        ring_blocks_m1 = 16'd15; host_rd_ptr = 16'd0;
        enable = 1'b1;
        tick();
        send_beat(8'h80);
        send_beat(8'h82);
        n_vec++;
        if ({err_code, blocks_total} !== {3'b100, 32'd1}) begin
            n_bad++;
            $display("FAIL tag_mismatch: code=%0d total=%0d want 4 1", err_code, blocks_total);
        end
    endtask

    task automatic test_wrap_fill();
        do_reset();
        ring_blocks_m1 = 16'd15; host_rd_ptr = 16'd14;
        enable = 1'b1;
        tick();
        send_beat(8'h80);
        send_beat(8'h81);
        n_vec++;
        if ({wr_ptr, fill_level} !== {16'd2, 17'd4}) begin
            n_bad++;
            $display("FAIL wrap_fill: wr=%0d fill=%0d want 2 4", wr_ptr, fill_level);
        end
        host_rd_ptr = 16'd20;
        send_beat(8'h82);
        n_vec++;
        if ({err_code, wr_ptr} !== {3'b101, 16'd2}) begin
            n_bad++;
            $display("FAIL rd_out_of_range: code=%0d wr=%0d want 5 2", err_code, wr_ptr);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        ring_blocks_m1 = 16'd15; host_rd_ptr = 16'd0; irq_threshold = 8'd1;
        enable = 1'b1;
        tick();
        send_beat(8'h80);
        send_beat(8'h81);
        #3;
        axi_aresetn = 1'b0;
        #1;
        n_vec++;
        if (dut_vec !== 73'd0) begin
            n_bad++;
            $display("FAIL async_reset: got %h want 0", dut_vec);
        end
        model_reset();
        tick();
        axi_aresetn = 1'b1;
        tick();
        n_vec++;
        if ({s_axis_sts_tready, halt_req} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_rerun: rdy=%b halt=%b want 1 0", s_axis_sts_tready, halt_req);
        end
        send_beat(8'h80);
        n_vec++;
        if ({wr_ptr, sts_err, blocks_total} !== {16'd1, 1'b0, 32'd1}) begin
            n_bad++;
            $display("FAIL reset_tag0: wr=%0d err=%b total=%0d want 1 0 1", wr_ptr, sts_err,
                     blocks_total);
        end
    endtask

    task automatic test_random();
        int unsigned m1;
        do_reset();
        for (int seg = 0; seg < 6; seg++) begin
            enable = 1'b0;
            s_axis_sts_tvalid = 1'b0;
            tick();
            m1 = $urandom_range(1, 7);
            ring_blocks_m1 = 16'(m1);
            host_rd_ptr = 16'd0;
            irq_threshold = 8'($urandom_range(0, 4));
            for (int c = 0; c < 400; c++) begin
                enable = ($urandom_range(0, 99) < ((m_mode >= MODE_HALT) ? 30 : 2)) ? 1'b0 : 1'b1;
                s_axis_sts_tvalid = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) < 8) s_axis_sts_tdata = {4'h8, 4'(m_tag)};
                else s_axis_sts_tdata = 8'($urandom);
                if ($urandom_range(0, 9) == 0) begin
                    if ($urandom_range(0, 9) == 0) host_rd_ptr = 16'(m1 + 1 + $urandom_range(0, 3));
                    else host_rd_ptr = 16'($urandom_range(0, m1));
                end
                err_clr = ($urandom_range(0, 19) == 0);
                irq_ack = ($urandom_range(0, 9) == 0);
                tick();
                n_vec++;
                if (dut_vec !== exp_vec()) begin
                    n_bad++;
                    $display("FAIL random_seg%0d_cyc%0d: got %h want %h", seg, c, dut_vec,
                             exp_vec());
                end
            end
        end
        err_clr = 1'b0;
        irq_ack = 1'b0;
        s_axis_sts_tvalid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_overrun();
        test_irq();
        test_fault();
        test_tag_mismatch();
        test_wrap_fill();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
